// File: rtl/cache_controller.sv
// Direct-mapped cache controller: sequences an external cache array (driven on the
// falling edge) and a handshaked RAM for hits, clean/dirty misses and flushes.
module cache_controller #(
  parameter int unsigned ramWidth      = 8,
  parameter int unsigned addrWidth     = 8,
  parameter int unsigned blockAddrBits = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpuReq,
  input  logic                 cpuWe,
  input  logic [addrWidth-1:0] cpuAddr,
  input  logic [ramWidth-1:0]  cpuWData,
  output logic [ramWidth-1:0]  cpuRData,
  output logic                 cpuReady,
  input  logic                 flushReq,
  output logic                 flushDone,
  output logic [1:0]           cacheCntrl,
  output logic [addrWidth-1:0] cacheAddr,
  output logic [ramWidth-1:0]  cacheDataIn,
  input  logic [ramWidth-1:0]  cacheDataOut,
  input  logic                 cacheHit,
  input  logic                 cacheClean,
  input  logic [ramWidth-1:0]  cacheWbData,
  input  logic [addrWidth-1:0] cacheWbAddr,
  output logic                 ramReq,
  output logic                 ramWe,
  output logic [addrWidth-1:0] ramAddr,
  output logic [ramWidth-1:0]  ramWData,
  input  logic [ramWidth-1:0]  ramRData,
  input  logic                 ramAck,
  output logic [7:0]           hitCount,
  output logic [7:0]           missCount
);

  if (blockAddrBits == 0 || blockAddrBits > addrWidth) begin : g_bad_index_width
    $error("cache_controller: blockAddrBits must be in 1..addrWidth");
  end

  typedef enum logic [2:0] {
    IDLE, CHECK, WB, WB_GAP, FILL, FILLWR, ACCESS, FLUSH
  } state_t;

  typedef enum logic [1:0] {
    CMD_CLR   = 2'b00,
    CMD_CHECK = 2'b01,
    CMD_READ  = 2'b10,
    CMD_WRITE = 2'b11
  } cmd_t;

  state_t               state, state_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [ramWidth-1:0]  wdata_q, wdata_d;

  cmd_t                 cntrl_d;
  logic [addrWidth-1:0] cache_addr_d;
  logic [ramWidth-1:0]  cache_din_d;
  logic [ramWidth-1:0]  rdata_d;
  logic                 ready_d;
  logic                 flush_done_d;
  logic                 ram_req_d;
  logic                 ram_we_d;
  logic [addrWidth-1:0] ram_addr_d;
  logic [ramWidth-1:0]  ram_wdata_d;
  logic [7:0]           hit_d;
  logic [7:0]           miss_d;

  always_comb begin
    state_d      = state;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    cntrl_d      = CMD_CHECK;
    cache_addr_d = cacheAddr;
    cache_din_d  = cacheDataIn;
    rdata_d      = cpuRData;
    ready_d      = 1'b0;
    flush_done_d = 1'b0;
    ram_req_d    = ramReq;
    ram_we_d     = ramWe;
    ram_addr_d   = ramAddr;
    ram_wdata_d  = ramWData;
    hit_d        = hitCount;
    miss_d       = missCount;

    unique case (state)
      IDLE: begin
        // Spend one idle cycle after any completion pulse so a still-held request is not re-taken.
        if (!cpuReady && !flushDone) begin
          if (flushReq) begin
            cntrl_d = CMD_CLR;
            state_d = FLUSH;
          end else if (cpuReq) begin
            addr_d       = cpuAddr;
            we_d         = cpuWe;
            wdata_d      = cpuWData;
            cache_addr_d = cpuAddr;
            state_d      = CHECK;
          end
        end
      end

      FLUSH: begin
        flush_done_d = 1'b1;
        hit_d        = '0;
        miss_d       = '0;
        state_d      = IDLE;
      end

      CHECK: begin
        if (cacheHit) begin
          hit_d        = (hitCount == 8'hFF) ? hitCount : hitCount + 8'd1;
          cntrl_d      = we_q ? CMD_WRITE : CMD_READ;
          cache_addr_d = addr_q;
          if (we_q) cache_din_d = wdata_q;
          state_d      = ACCESS;
        end else begin
          miss_d    = (missCount == 8'hFF) ? missCount : missCount + 8'd1;
          ram_req_d = 1'b1;
          if (cacheClean) begin
            ram_we_d   = 1'b0;
            ram_addr_d = addr_q;
            state_d    = FILL;
          end else begin
            ram_we_d    = 1'b1;
            ram_addr_d  = cacheWbAddr;
            ram_wdata_d = cacheWbData;
            state_d     = WB;
          end
        end
      end

      WB: begin
        if (ramAck) begin
          ram_req_d = 1'b0;
          state_d   = WB_GAP;
        end
      end

      WB_GAP: begin
        ram_req_d  = 1'b1;
        ram_we_d   = 1'b0;
        ram_addr_d = addr_q;
        state_d    = FILL;
      end

      FILL: begin
        if (ramAck) begin
          ram_req_d    = 1'b0;
          cntrl_d      = CMD_WRITE;
          cache_din_d  = ramRData;
          cache_addr_d = addr_q;
          state_d      = FILLWR;
        end
      end

      FILLWR: begin
        cntrl_d      = we_q ? CMD_WRITE : CMD_READ;
        cache_addr_d = addr_q;
        if (we_q) cache_din_d = wdata_q;
        state_d      = ACCESS;
      end

      ACCESS: begin
        if (!we_q) rdata_d = cacheDataOut;
        ready_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cacheCntrl  <= CMD_CLR;
      cacheAddr   <= '0;
      cacheDataIn <= '0;
      cpuRData    <= '0;
      cpuReady    <= 1'b0;
      flushDone   <= 1'b0;
      ramReq      <= 1'b0;
      ramWe       <= 1'b0;
      ramAddr     <= '0;
      ramWData    <= '0;
      hitCount    <= '0;
      missCount   <= '0;
    end else begin
      state       <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cacheCntrl  <= cntrl_d;
      cacheAddr   <= cache_addr_d;
      cacheDataIn <= cache_din_d;
      cpuRData    <= rdata_d;
      cpuReady    <= ready_d;
      flushDone   <= flush_done_d;
      ramReq      <= ram_req_d;
      ramWe       <= ram_we_d;
      ramAddr     <= ram_addr_d;
      ramWData    <= ram_wdata_d;
      hitCount    <= hit_d;
      missCount   <= miss_d;
    end
  end

endmodule
